data_sram_axi_bridge: RTL and testbench
=======================================

DATA_SRAM_AXI_BRIDGE -- requirements
Module: data_sram_axi_bridge

Interface
REQ-001 SHALL have port clk, input, 1: single clock, all state on rising edge.
REQ-002 SHALL have port resetn, input, 1: synchronous, active-high reset (asserted = 1, despite the name).
REQ-003 SHALL have ports data_sram_en input 1, data_sram_wen input 4, data_sram_addr input 32, data_sram_wdata input 32: the core data request (wen=0000 means read).
REQ-004 SHALL have port data_sram_rdata, output, 32: read data returned to the core.
REQ-005 SHALL have port memory_stall, output, 1: holds the core while a request is outstanding.
REQ-006 SHALL have port longest_stall_m, input, 1: the core global stall; while high the core holds its request.
REQ-007 SHALL have AXI4 master ports araddr 32, arvalid, arready, rdata 32, rvalid, rready, awaddr 32, awsize 3, awvalid, awready, wdata 32, wstrb 4, wvalid, wready, bvalid, bready, with the usual directions; arsize=3'd2, arlen/awlen=0, ids=0 and wlast=1 are constant.

Function
REQ-008 SHALL implement the states IDLE, RD_AR, RD_R, WR_AWW, WR_B and DONE.
REQ-009 In IDLE with data_sram_en=1, SHALL latch addr, wen and wdata, then go to RD_AR (wen=0) or WR_AWW (wen!=0).
REQ-010 memory_stall SHALL be combinational: 1 when (IDLE and data_sram_en) or the state is RD_AR, RD_R, WR_AWW or WR_B; 0 in DONE and in IDLE without a request.
REQ-011 RD_AR SHALL drive arvalid=1 and araddr=latched addr; on arready it SHALL go to RD_R.
REQ-012 RD_R SHALL drive rready=1; on rvalid it SHALL capture rdata into data_sram_rdata and go to DONE. rresp is ignored.
REQ-013 WR_AWW SHALL drive awvalid and wvalid independently.
  - Each valid drops after its own handshake; aw_done and w_done flags record completion.
  - The state SHALL advance to WR_B when both are done, including when both complete in the same cycle.
REQ-014 wstrb SHALL equal the latched wen.
REQ-015 awsize SHALL be derived from the latched wen: 1111 -> 2; 0011 or 1100 -> 1; any single bit -> 0; other patterns -> 2.
REQ-016 WR_B SHALL drive bready=1; on bvalid it SHALL go to DONE. bresp is ignored.
REQ-017 DONE SHALL go to IDLE in the first cycle longest_stall_m=0. This prevents the same held request from being reissued.
REQ-018 data_sram_rdata SHALL hold its last captured value until the next read completes.
REQ-019 Latency SHALL be as follows: a read with zero-wait AXI slave returns data with memory_stall high for exactly 3 cycles (request cycle, RD_AR, RD_R).
REQ-020 The block SHALL have at most one outstanding transaction; AXI valid signals SHALL never drop before their handshake, except on reset.
REQ-021 Addresses SHALL pass unmodified; address mapping is done upstream.

Reset
REQ-022 On resetn=1 the state SHALL be IDLE and aw_done=w_done=0.
REQ-023 On reset all AXI valid/ready outputs SHALL be 0 and data_sram_rdata SHALL be 0, taking effect in the next cycle.
REQ-024 Reset mid-transaction SHALL abandon the transaction with no completion to the core. System-level reset of the AXI slave is required.

Structure
REQ-025 The state encoding and the constants AXI_SIZE_WORD=2, AXI_SIZE_HALF=1 and AXI_SIZE_BYTE=0 SHALL live in the shared package axi_bridge_pkg.
REQ-026 The block SHALL be a single module with no sub-modules. An inst-side bridge SHALL reuse the read path by instantiating this module with wen tied to 0.

Verification
REQ-027 Read: en=1, wen=0, addr=0x0000_1000; slave arready after 2 cycles and rdata=0xDEAD_BEEF 1 cycle later -> rdata=0xDEAD_BEEF and memory_stall falls in the cycle after rvalid.
REQ-028 Byte write: wen=0100, wdata=0x00AB_0000, addr=0x0000_2002; awready before wready -> awsize=0, wstrb=0100, single AW and W handshake, one bready handshake, then DONE.
REQ-029 Simultaneous handshake: awready=wready=1 in the same cycle with wen=1111 -> WR_B next cycle, awsize=2, no second valid pulse.
REQ-030 Held request: longest_stall_m=1 for 3 cycles after DONE with en held -> exactly one AR issued, then IDLE accepts a new request after the stall drops.
REQ-031 Reset mid-read (resetn=1 during RD_R) -> IDLE next cycle, rready=0, rdata=0, memory_stall=0 when en=0.
REQ-032 Back-to-back read then write at different addresses -> two transactions, correct order, no overlap of AR and AW activity.

Source files
------------

// File: rtl/axi_bridge_pkg.sv
// Shared types and constants for the data-side SRAM-to-AXI bridge.
// Holds the FSM encoding and the AXI transfer size codes.
package axi_bridge_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_AR,
    RD_R,
    WR_AWW,
    WR_B,
    DONE
  } state_e;

  localparam logic [2:0] AXI_SIZE_WORD = 3'd2;
  localparam logic [2:0] AXI_SIZE_HALF = 3'd1;
  localparam logic [2:0] AXI_SIZE_BYTE = 3'd0;

  // Map a byte-enable pattern to an AXI size code.
  // Unusual patterns fall back to a full word; wstrb still masks bytes.
  function automatic logic [2:0] wen_to_size(
    input logic [3:0] wen
  );
    logic [2:0] size;
    unique case (wen)
      4'b1111: size = AXI_SIZE_WORD;
      4'b0011,
      4'b1100: size = AXI_SIZE_HALF;
      4'b0001,
      4'b0010,
      4'b0100,
      4'b1000: size = AXI_SIZE_BYTE;
      default: size = AXI_SIZE_WORD;
    endcase
    return size;
  endfunction

endpackage

// File: rtl/data_sram_axi_bridge.sv
// Turns a single SRAM-style core data request into one AXI4 transaction.
// One transaction in flight; DONE waits out the core's global stall.
module data_sram_axi_bridge
  import axi_bridge_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,

  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_wen,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  output logic        memory_stall,
  input  logic        longest_stall_m,

  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic        arvalid,
  input  logic        arready,
  input  logic [31:0] rdata,
  input  logic        rvalid,
  output logic        rready,

  output logic [3:0]  awid,
  output logic [31:0] awaddr,
  output logic [7:0]  awlen,
  output logic [2:0]  awsize,
  output logic        awvalid,
  input  logic        awready,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wlast,
  output logic        wvalid,
  input  logic        wready,
  input  logic        bvalid,
  output logic        bready
);

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  wen_q, wen_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        aw_done_q, aw_done_d;
  logic        w_done_q, w_done_d;
  logic        aw_hs;
  logic        w_hs;

  // Register state, the latched request and returned read data.
  always_ff @(posedge clk) begin
    if (resetn) begin
      state_q   <= IDLE;
      addr_q    <= 32'h0;
      wen_q     <= 4'h0;
      wdata_q   <= 32'h0;
      rdata_q   <= 32'h0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wen_q     <= wen_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

  // Next-state logic and state-decoded AXI handshakes.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wen_d     = wen_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    arvalid   = 1'b0;
    rready    = 1'b0;
    awvalid   = 1'b0;
    wvalid    = 1'b0;
    bready    = 1'b0;
    aw_hs     = 1'b0;
    w_hs      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (data_sram_en) begin
          addr_d    = data_sram_addr;
          wen_d     = data_sram_wen;
          wdata_d   = data_sram_wdata;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          if (data_sram_wen == 4'h0) begin
            state_d = RD_AR;
          end else begin
            state_d = WR_AWW;
          end
        end
      end
      RD_AR: begin
        arvalid = 1'b1;
        if (arready) begin
          state_d = RD_R;
        end
      end
      RD_R: begin
        rready = 1'b1;
        if (rvalid) begin
          rdata_d = rdata;
          state_d = DONE;
        end
      end
      WR_AWW: begin
        awvalid   = !aw_done_q;
        wvalid    = !w_done_q;
        aw_hs     = awvalid && awready;
        w_hs      = wvalid && wready;
        aw_done_d = aw_done_q || aw_hs;
        w_done_d  = w_done_q || w_hs;
        if (aw_done_d && w_done_d) begin
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = WR_B;
        end
      end
      WR_B: begin
        bready = 1'b1;
        if (bvalid) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (!longest_stall_m) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Stall the core from the request cycle until the reply lands.
  always_comb begin
    memory_stall = 1'b0;
    unique case (state_q)
      IDLE:    memory_stall = data_sram_en;
      RD_AR,
      RD_R,
      WR_AWW,
      WR_B:    memory_stall = 1'b1;
      default: memory_stall = 1'b0;
    endcase
  end

  assign data_sram_rdata = rdata_q;

  assign arid   = 4'h0;
  assign araddr = addr_q;
  assign arlen  = 8'h0;
  assign arsize = AXI_SIZE_WORD;

  assign awid   = 4'h0;
  assign awaddr = addr_q;
  assign awlen  = 8'h0;
  assign awsize = wen_to_size(wen_q);
  assign wdata  = wdata_q;
  assign wstrb  = wen_q;
  assign wlast  = 1'b1;

endmodule

// File: tb/tb_data_sram_axi_bridge.sv
// Directed bench for data_sram_axi_bridge.
// Vector table of transactions plus reset-mid-read sequence.
module tb_data_sram_axi_bridge;

  typedef struct {
    logic [3:0]  wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          ar_dly;
    int          r_dly;
    int          aw_dly;
    int          w_dly;
    int          b_dly;
    int          hold;
    logic [2:0]  exp_size;
    int          exp_stall;
    logic [31:0] exp_rdata;
  } vec_t;

  logic        clk = 1'b0;
  logic        resetn;
  logic        data_sram_en;
  logic [3:0]  data_sram_wen;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic [31:0] data_sram_rdata;
  logic        memory_stall;
  logic        longest_stall_m;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic        rvalid;
  logic        rready;
  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;
  logic        bvalid;
  logic        bready;

  int checks   = 0;
  int failures = 0;

  vec_t vecs[10];

  always #5 clk = ~clk;

  data_sram_axi_bridge dut (
    .clk             (clk),
    .resetn          (resetn),
    .data_sram_en    (data_sram_en),
    .data_sram_wen   (data_sram_wen),
    .data_sram_addr  (data_sram_addr),
    .data_sram_wdata (data_sram_wdata),
    .data_sram_rdata (data_sram_rdata),
    .memory_stall    (memory_stall),
    .longest_stall_m (longest_stall_m),
    .arid            (arid),
    .araddr          (araddr),
    .arlen           (arlen),
    .arsize          (arsize),
    .arvalid         (arvalid),
    .arready         (arready),
    .rdata           (rdata),
    .rvalid          (rvalid),
    .rready          (rready),
    .awid            (awid),
    .awaddr          (awaddr),
    .awlen           (awlen),
    .awsize          (awsize),
    .awvalid         (awvalid),
    .awready         (awready),
    .wdata           (wdata),
    .wstrb           (wstrb),
    .wlast           (wlast),
    .wvalid          (wvalid),
    .wready          (wready),
    .bvalid          (bvalid),
    .bready          (bready)
  );

  task automatic chk(
    input string       name,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h",
               name, act, exp);
    end
  endtask

  function automatic vec_t mk(
    input logic [3:0]  wen,
    input logic [31:0] addr,
    input logic [31:0] wd,
    input logic [31:0] rd,
    input int ar_dly, input int r_dly,
    input int aw_dly, input int w_dly,
    input int b_dly,  input int hold,
    input logic [2:0]  size,
    input int          stall,
    input logic [31:0] exp_rd
  );
    vec_t v;
    v.wen = wen; v.addr = addr;
    v.wdata = wd; v.rdata = rd;
    v.ar_dly = ar_dly; v.r_dly = r_dly;
    v.aw_dly = aw_dly; v.w_dly = w_dly;
    v.b_dly = b_dly; v.hold = hold;
    v.exp_size = size; v.exp_stall = stall;
    v.exp_rdata = exp_rd;
    return v;
  endfunction

  task automatic slave_idle();
    arready = 1'b0;
    rvalid  = 1'b0;
    rdata   = 32'h0;
    awready = 1'b0;
    wready  = 1'b0;
    bvalid  = 1'b0;
  endtask

  // Entered and left at posedge+1; the DUT is in IDLE on entry.
  task automatic run_vec(input vec_t v, input int idx);
    int ar_k = 0, aw_k = 0, w_k = 0;
    int r_k = 0, b_k = 0;
    int ar_n = 0, r_n = 0, aw_n = 0;
    int w_n = 0, b_n = 0;
    int stall_n = 0, done_n = 0;
    bit in_done = 0, fin = 0, ovl = 0;
    bit is_rd;
    logic [31:0] g_araddr = 32'h0;
    logic [31:0] g_awaddr = 32'h0;
    logic [31:0] g_wdata  = 32'h0;
    logic [3:0]  g_wstrb  = 4'h0;
    logic [2:0]  g_size   = 3'h7;
    is_rd = (v.wen == 4'h0);
    data_sram_en    = 1'b1;
    data_sram_wen   = v.wen;
    data_sram_addr  = v.addr;
    data_sram_wdata = v.wdata;
    longest_stall_m = (v.hold > 0);
    for (int c = 0; c < 100 && !fin; c++) begin
      arready = arvalid && (ar_k >= v.ar_dly);
      rvalid  = (ar_n > 0) && (r_n == 0) &&
                (r_k >= v.r_dly);
      rdata   = rvalid ? v.rdata : 32'hBAD0_0BAD;
      awready = awvalid && (aw_k >= v.aw_dly);
      wready  = wvalid && (w_k >= v.w_dly);
      bvalid  = (aw_n > 0) && (w_n > 0) &&
                (b_n == 0) && (b_k >= v.b_dly);
      #1;
      if (in_done) begin
        done_n++;
        chk($sformatf("v%0d_done_stall", idx),
            {31'h0, memory_stall}, 32'h0);
      end else if (memory_stall) begin
        stall_n++;
      end else begin
        in_done = 1;
        done_n  = 1;
      end
      if (in_done && !longest_stall_m) fin = 1;
      if (is_rd && (awvalid || wvalid)) ovl = 1;
      if (!is_rd && arvalid) ovl = 1;
      if (ar_n > 0) r_k++;
      if (aw_n > 0 && w_n > 0) b_k++;
      if (arvalid) ar_k++;
      if (awvalid) aw_k++;
      if (wvalid) w_k++;
      if (arvalid && arready) begin
        ar_n++;
        g_araddr = araddr;
      end
      if (rvalid && rready) r_n++;
      if (awvalid && awready) begin
        aw_n++;
        g_awaddr = awaddr;
        g_size   = awsize;
      end
      if (wvalid && wready) begin
        w_n++;
        g_wdata = wdata;
        g_wstrb = wstrb;
      end
      if (bvalid && bready) b_n++;
      @(posedge clk);
      #1;
      if (in_done && done_n >= v.hold)
        longest_stall_m = 1'b0;
    end
    slave_idle();
    chk($sformatf("v%0d_finished", idx),
        {31'h0, fin}, 32'h1);
    chk($sformatf("v%0d_stall_cycles", idx),
        stall_n, v.exp_stall);
    chk($sformatf("v%0d_overlap", idx),
        {31'h0, ovl}, 32'h0);
    chk($sformatf("v%0d_sram_rdata", idx),
        data_sram_rdata, v.exp_rdata);
    if (is_rd) begin
      chk($sformatf("v%0d_ar_count", idx), ar_n, 1);
      chk($sformatf("v%0d_r_count", idx), r_n, 1);
      chk($sformatf("v%0d_aw_count", idx), aw_n, 0);
      chk($sformatf("v%0d_araddr", idx),
          g_araddr, v.addr);
    end else begin
      chk($sformatf("v%0d_ar_count", idx), ar_n, 0);
      chk($sformatf("v%0d_aw_count", idx), aw_n, 1);
      chk($sformatf("v%0d_w_count", idx), w_n, 1);
      chk($sformatf("v%0d_b_count", idx), b_n, 1);
      chk($sformatf("v%0d_awaddr", idx),
          g_awaddr, v.addr);
      chk($sformatf("v%0d_awsize", idx),
          {29'h0, g_size}, {29'h0, v.exp_size});
      chk($sformatf("v%0d_wstrb", idx),
          {28'h0, g_wstrb}, {28'h0, v.wen});
      chk($sformatf("v%0d_wdata", idx),
          g_wdata, v.wdata);
    end
  endtask

  initial begin
    vecs[0] = mk(4'b0000, 32'h0000_1000, 32'h0,
                 32'hDEAD_BEEF, 2, 1, 0, 0, 0, 0,
                 3'd2, 6, 32'hDEAD_BEEF);
    vecs[1] = mk(4'b0000, 32'h0000_3000, 32'h0,
                 32'h1234_5678, 0, 0, 0, 0, 0, 3,
                 3'd2, 3, 32'h1234_5678);
    vecs[2] = mk(4'b0100, 32'h0000_2002,
                 32'h00AB_0000, 32'h0,
                 0, 0, 0, 2, 1, 0,
                 3'd0, 6, 32'h1234_5678);
    vecs[3] = mk(4'b1111, 32'h0000_4000,
                 32'hCAFE_F00D, 32'h0,
                 0, 0, 0, 0, 0, 2,
                 3'd2, 3, 32'h1234_5678);
    vecs[4] = mk(4'b0000, 32'h0000_5004, 32'h0,
                 32'hA5A5_5A5A, 1, 0, 0, 0, 0, 0,
                 3'd2, 4, 32'hA5A5_5A5A);
    vecs[5] = mk(4'b0011, 32'h0000_6000,
                 32'h0000_BEEF, 32'h0,
                 0, 0, 2, 0, 0, 0,
                 3'd1, 5, 32'hA5A5_5A5A);
    vecs[6] = mk(4'b1100, 32'h0000_6002,
                 32'h1234_0000, 32'h0,
                 0, 0, 1, 1, 0, 0,
                 3'd1, 4, 32'hA5A5_5A5A);
    vecs[7] = mk(4'b1000, 32'h0000_7003,
                 32'h5500_0000, 32'h0,
                 0, 0, 0, 0, 2, 0,
                 3'd0, 5, 32'hA5A5_5A5A);
    vecs[8] = mk(4'b0110, 32'h0000_8000,
                 32'h0077_6600, 32'h0,
                 0, 0, 0, 0, 0, 0,
                 3'd2, 3, 32'hA5A5_5A5A);
    vecs[9] = mk(4'b0111, 32'h0000_9000,
                 32'h00C0_FFEE, 32'h0,
                 0, 0, 1, 0, 0, 0,
                 3'd2, 4, 32'hA5A5_5A5A);

    resetn          = 1'b1;
    data_sram_en    = 1'b0;
    data_sram_wen   = 4'h0;
    data_sram_addr  = 32'h0;
    data_sram_wdata = 32'h0;
    longest_stall_m = 1'b0;
    slave_idle();
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b0;
    #1;
    chk("rst_stall", {31'h0, memory_stall}, 32'h0);
    chk("rst_arvalid", {31'h0, arvalid}, 32'h0);
    chk("rst_rready", {31'h0, rready}, 32'h0);
    chk("rst_awvalid", {31'h0, awvalid}, 32'h0);
    chk("rst_wvalid", {31'h0, wvalid}, 32'h0);
    chk("rst_bready", {31'h0, bready}, 32'h0);
    chk("rst_rdata", data_sram_rdata, 32'h0);
    chk("const_arsize", {29'h0, arsize}, 32'h2);
    chk("const_lens", {16'h0, arlen, awlen}, 32'h0);
    chk("const_ids", {24'h0, arid, awid}, 32'h0);
    chk("const_wlast", {31'h0, wlast}, 32'h1);
    @(posedge clk);
    #1;

    for (int i = 0; i < 10; i++) begin
      run_vec(vecs[i], i);
    end
    data_sram_en = 1'b0;
    #1;
    chk("idle_stall", {31'h0, memory_stall}, 32'h0);

    // Reset while waiting for read data.
    data_sram_en   = 1'b1;
    data_sram_wen  = 4'h0;
    data_sram_addr = 32'h0000_A000;
    begin
      bit seen_r = 0;
      for (int c = 0; c < 20 && !seen_r; c++) begin
        arready = arvalid;
        #1;
        if (rready) begin
          seen_r = 1;
        end else begin
          @(posedge clk);
          #1;
        end
      end
      chk("mid_reached_rd_r", {31'h0, seen_r}, 32'h1);
    end
    slave_idle();
    resetn       = 1'b1;
    data_sram_en = 1'b0;
    @(posedge clk);
    #1;
    resetn = 1'b0;
    #1;
    chk("mid_rready", {31'h0, rready}, 32'h0);
    chk("mid_arvalid", {31'h0, arvalid}, 32'h0);
    chk("mid_rdata", data_sram_rdata, 32'h0);
    chk("mid_stall", {31'h0, memory_stall}, 32'h0);
    @(posedge clk);
    #1;
    chk("post_stall", {31'h0, memory_stall}, 32'h0);
    chk("post_arvalid", {31'h0, arvalid}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
